// File: rtl/dac_serializer.sv
// Mono-to-stereo DAC serializer: one-deep sample buffer, self-generated bclk/lrclk, 32-slot frames.
// Define I2S_DELAY_EN for standard I2S (sdata delayed one bclk); otherwise left-justified.
module dac_serializer #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        frame_start,
  output logic        underrun
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SLOT_W   = 5;
  localparam int unsigned FRAME_W  = 2 * SAMPLE_W;
  localparam int unsigned DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(31);

  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_bclk;
  logic [SLOT_W-1:0]   r_slot;
  logic                r_lrclk;
  // Bits still to be emitted this frame; the emitted bit lives in r_sdata.
  logic [FRAME_W-2:0]  r_shift;
  logic                r_sdata;
  logic [SAMPLE_W-1:0] r_last_sample;
  logic [SAMPLE_W-1:0] r_hold_data;
  logic                r_hold_full;
  logic                r_frame_start;
  logic                r_underrun;
`ifdef I2S_DELAY_EN
  logic                r_lj_bit;
`endif

  logic                w_div_wrap;
  logic                w_fall_tick;
  logic                w_frame_tick;
  logic                w_xfer;
  logic [SAMPLE_W-1:0] w_sample;
  logic                w_starved;
  logic [FRAME_W-1:0]  w_shift_next;
  logic [SLOT_W-1:0]   w_slot_next;

  assign w_div_wrap   = (r_div_cnt == DIV_LAST);
  assign w_fall_tick  = w_div_wrap & r_bclk;
  assign w_frame_tick = w_fall_tick & (r_slot == SLOT_LAST);
  assign w_xfer       = sample_valid & ~r_hold_full;
  assign w_slot_next  = r_slot + SLOT_W'(1);

  // Frame sample source: buffered sample, same-cycle bypass, or repeat on starvation.
  always_comb begin
    w_sample  = r_last_sample;
    w_starved = 1'b0;
    if (r_hold_full) begin
      w_sample = r_hold_data;
    end else if (w_xfer) begin
      w_sample = sample_in;
    end else begin
      w_starved = 1'b1;
    end
  end

  assign w_shift_next = w_frame_tick ? {w_sample, w_sample} : {r_shift, 1'b0};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div_cnt     <= '0;
      r_bclk        <= 1'b0;
      r_slot        <= SLOT_LAST;
      r_lrclk       <= 1'b1;
      r_shift       <= '0;
      r_sdata       <= 1'b0;
      r_last_sample <= '0;
      r_hold_data   <= '0;
      r_hold_full   <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
`ifdef I2S_DELAY_EN
      r_lj_bit      <= 1'b0;
`endif
    end else begin
      r_frame_start <= w_frame_tick;
      r_underrun    <= w_frame_tick & w_starved;
      r_div_cnt     <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
      if (w_div_wrap) begin
        r_bclk <= ~r_bclk;
      end
      if (w_fall_tick) begin
        r_slot  <= w_slot_next;
        r_lrclk <= w_slot_next[SLOT_W-1];
        r_shift <= w_shift_next[FRAME_W-2:0];
`ifdef I2S_DELAY_EN
        r_lj_bit <= w_shift_next[FRAME_W-1];
        r_sdata  <= r_lj_bit;
`else
        r_sdata  <= w_shift_next[FRAME_W-1];
`endif
      end
      if (w_frame_tick) begin
        r_last_sample <= w_sample;
        r_hold_full   <= 1'b0;
      end else if (w_xfer) begin
        r_hold_data <= sample_in;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign sample_ready = ~r_hold_full;
  assign bclk         = r_bclk;
  assign lrclk        = r_lrclk;
  assign sdata        = r_sdata;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_dac_serializer.sv
// Scoreboard bench for dac_serializer: frame-level reference model predicts each frame's
// sample, underrun flag and 32-bit serial pattern; a monitor checks pins every clock.
module tb_dac_serializer;
  localparam int unsigned D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, bclk, lrclk, sdata, frame_start, underrun;

  dac_serializer #(.BCLK_DIV(D)) dut (
    .clock(clock), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] bits;
    logic        und;
  } frame_t;

  int          n = 0;
  int          tests = 0;
  int          fails = 0;
  frame_t      exp_q[$];
  logic [15:0] pend_q[$];
  logic [15:0] last_s = '0;
  logic        prev_lsb = 1'b0;
  logic        coll_act = 1'b0;
  int          coll_cnt = 0;
  logic [31:0] coll_bits = '0;
  frame_t      cur;
  frame_t      f;
  logic [15:0] s;
  logic        bclk_prev = 1'b0;
  int          ticks, slot, m;
  logic        fs, xfer;

  // Clocks since reset release; stays 0 while reset is held.
  always @(posedge clock) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h (clock %0d)", name, got, want, n);
    end
  endtask

  // Monitor + reference model, evaluated mid-cycle when everything is stable.
  always @(negedge clock) begin
    ticks = (n >= 2*D) ? (n - 2*D) / (2*D) + 1 : 0;
    slot  = (31 + ticks) % 32;
    fs    = (n >= 2*D) && (((n - 2*D) % (64*D)) == 0);
    chk("bclk", 32'(bclk), 32'((n / D) % 2));
    chk("lrclk", 32'(lrclk), 32'(slot >= 16));
    chk("frame_start", 32'(frame_start), 32'(fs));
    chk("sample_ready", 32'(sample_ready), 32'(pend_q.size() == 0));
    if (n < 2*D) chk("sdata_idle", 32'(sdata), 32'd0);
    if (!fs)     chk("underrun_idle", 32'(underrun), 32'd0);

    if (coll_act && bclk && !bclk_prev) begin
      coll_bits = {coll_bits[30:0], sdata};
      coll_cnt++;
      if (coll_cnt == 32) begin
        chk("frame_bits", coll_bits, cur.bits);
        coll_act = 1'b0;
      end
    end
    if (fs) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL frame_pop: got frame_start want no frame (clock %0d)", n);
      end else begin
        cur = exp_q.pop_front();
        chk("underrun", 32'(underrun), 32'(cur.und));
        coll_act  = 1'b1;
        coll_cnt  = 0;
        coll_bits = '0;
      end
    end
    bclk_prev = bclk;

    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      last_s   = '0;
      prev_lsb = 1'b0;
      coll_act = 1'b0;
    end else begin
      m    = n + 1;
      xfer = sample_valid && (pend_q.size() == 0);
      if (m >= 2*D && ((m - 2*D) % (64*D)) == 0) begin
        if (pend_q.size() > 0) begin
          s = pend_q.pop_front();
          f.und = 1'b0;
        end else if (xfer) begin
          s = sample_in;
          f.und = 1'b0;
        end else begin
          s = last_s;
          f.und = 1'b1;
        end
        last_s = s;
`ifdef I2S_DELAY_EN
        f.bits = {prev_lsb, s, s[15:1]};
`else
        f.bits = {s, s};
`endif
        prev_lsb = s[0];
        exp_q.push_back(f);
      end else if (xfer) begin
        pend_q.push_back(sample_in);
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input int k);
    reset = 1'b1;
    cycles(k);
    reset = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    sample_in    = d;
    sample_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (sample_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    sample_in    = 16'($urandom);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: got ready=0 want ready=1 for sample %h", d);
    end
  endtask

  initial begin
    // Reset and idle: underrun frames of zeros.
    cycles(3);
    reset = 1'b0;
    cycles(300);

    // Bypass transfer exactly at the first frame start, then repeat on underrun.
    do_reset(2);
    cycles(7);
    sample_in    = 16'hA5C3;
    sample_valid = 1'b1;
    cycles(1);
    sample_valid = 1'b0;
    sample_in    = 16'h0000;
    cycles(600);

    // Backpressure: second sample waits for the frame start.
    send(16'h1234);
    send(16'h5678);
    cycles(600);

    // LSB/MSB pair that exposes the I2S one-bit delay.
    send(16'h0001);
    send(16'h8000);
    cycles(600);

    // Reset in slot 10 of a frame.
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      if (frame_start) break;
    end
    @(posedge clock);
    #1;
    cycles(2*D*10);
    do_reset(1);
    cycles(300);

    // Random traffic with sparse and bursty valid.
    for (int k = 0; k < 3000; k++) begin
      sample_valid = ($urandom_range(0, 7) == 0) || (k > 2000 && k < 2300);
      sample_in    = 16'($urandom);
      cycles(1);
    end
    sample_valid = 1'b0;
    cycles(600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
